adam_periph_uart_tx_ctrl: RTL and testbench

//  Sequencer between the UART register file and the UART transmitter (TX) datapath. Buffers outgoing

---
 rtl/adam_periph_uart_pkg.sv | 40 ++++
 rtl/adam_periph_uart_tx_fifo.sv | 59 +++++
 rtl/adam_periph_uart_tx_ctrl.sv | 123 ++++++++++++
 tb/tb_adam_periph_uart_tx_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_periph_uart_pkg.sv
// Shared types for the UART TX control path: config record, its reset value and the
// sequencer state encoding.
package adam_periph_uart_pkg;

   localparam int unsigned BAUD_W = 32;

   typedef struct packed {
      logic              parity_select;
      logic              parity_control;
      logic [3:0]        data_length;
      logic              stop_bits;
      logic [BAUD_W-1:0] baud_rate;
   } cfg_t;

   localparam cfg_t CFG_RST = '{
      parity_select:  1'b0,
      parity_control: 1'b0,
      data_length:    4'd8,
      stop_bits:      1'b0,
      baud_rate:      '0
   };

   typedef enum logic [2:0] {
      PAUSED,
      RUN,
      DRAIN_C,
      DRAIN_P,
      APPLY,
      RESUME
   } ctrl_state_t;

   // Reset config with the instance-specific baud divider folded in.
   function automatic cfg_t cfg_reset(input logic [BAUD_W-1:0] baud);
      cfg_t c;
      c           = CFG_RST;
      c.baud_rate = baud;
      return c;
   endfunction

endpackage

// File: rtl/adam_periph_uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter; head word is always visible
// on o_data, pops take effect on the next clock.
module adam_periph_uart_tx_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_push,
   input  logic [DATA_WIDTH-1:0]        i_data,
   input  logic                         i_pop,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(FIFO_DEPTH):0]  o_count
);

   logic [DATA_WIDTH-1:0]          r_mem [FIFO_DEPTH];
   logic [$clog2(FIFO_DEPTH)-1:0]  r_wr_ptr;
   logic [$clog2(FIFO_DEPTH)-1:0]  r_rd_ptr;
   logic [$clog2(FIFO_DEPTH):0]    r_count;
   logic                           w_push;
   logic                           w_pop;

   assign o_full  = (r_count == FIFO_DEPTH[$clog2(FIFO_DEPTH):0]);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/adam_periph_uart_tx_ctrl.sv
// Sequencer between the UART register file and the TX datapath: buffers words, feeds TX
// through valid/ready, and changes config only while TX is paused.
module adam_periph_uart_tx_ctrl
   import adam_periph_uart_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           FIFO_DEPTH = 8,
   parameter logic [DATA_WIDTH-1:0] RST_BAUD   = '0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_pause_req,
   output logic                         o_pause_ack,
   output logic                         o_tx_pause_req,
   input  logic                         i_tx_pause_ack,
   input  cfg_t                         i_cfg,
   input  logic                         i_cfg_valid,
   output logic                         o_cfg_ready,
   output cfg_t                         o_cfg,
   input  logic [DATA_WIDTH-1:0]        i_wr_data,
   input  logic                         i_wr_valid,
   output logic                         o_wr_ready,
   output logic [DATA_WIDTH-1:0]        o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
   output logic                         o_busy
);

   ctrl_state_t r_state;
   ctrl_state_t w_state_nxt;
   logic        r_pause_ack;
   logic        r_tx_pause_req;
   cfg_t        r_cfg;
   logic        w_apply;
   logic        w_full;
   logic        w_empty;

   adam_periph_uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_wr_valid),
      .i_data  (i_wr_data),
      .i_pop   (o_tx_valid && i_tx_ready),
      .o_data  (o_tx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count)
   );

   // tx_valid tracks FIFO occupancy; the head only moves on a completed handshake, so
   // valid and data stay stable for the whole frame.
   assign o_tx_valid     = !w_empty;
   assign o_wr_ready     = !w_full;
   assign o_busy         = !w_empty;
   assign o_pause_ack    = r_pause_ack;
   assign o_tx_pause_req = r_tx_pause_req;
   assign o_cfg          = r_cfg;
   assign o_cfg_ready    = w_apply;

   always_comb begin
      w_state_nxt = r_state;
      w_apply     = 1'b0;
      case (r_state)
         RUN: begin
            if (i_pause_req) begin
               w_state_nxt = DRAIN_P;
            end else if (i_cfg_valid) begin
               w_state_nxt = DRAIN_C;
            end
         end
         DRAIN_C: begin
            if (i_tx_pause_ack) begin
               w_state_nxt = APPLY;
            end
         end
         DRAIN_P: begin
            if (i_tx_pause_ack) begin
               w_state_nxt = PAUSED;
            end
         end
         APPLY: begin
            w_apply     = 1'b1;
            w_state_nxt = i_pause_req ? PAUSED : RESUME;
         end
         PAUSED: begin
            w_apply = i_cfg_valid && i_tx_pause_ack;
            if (!i_pause_req) begin
               w_state_nxt = RESUME;
            end
         end
         RESUME: begin
            if (i_pause_req) begin
               w_state_nxt = DRAIN_P;
            end else if (!i_tx_pause_ack) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = PAUSED;
      endcase
   end

   // Handshake outputs are registered from the next state so they change with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= PAUSED;
         r_pause_ack    <= 1'b1;
         r_tx_pause_req <= 1'b1;
         r_cfg          <= cfg_reset(BAUD_W'(RST_BAUD));
      end else begin
         r_state        <= w_state_nxt;
         r_pause_ack    <= (w_state_nxt == PAUSED);
         r_tx_pause_req <= (w_state_nxt != RUN) && (w_state_nxt != RESUME);
         if (w_apply) begin
            r_cfg <= i_cfg;
         end
      end
   end

endmodule

// File: tb/tb_adam_periph_uart_tx_ctrl.sv
// Directed bench for adam_periph_uart_tx_ctrl with a behavioural UART TX partner that
// serialises frames from cfg_out and answers the pause and data handshakes.
module tb_adam_periph_uart_tx_ctrl;
   import adam_periph_uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pause_req;
   logic        pause_ack;
   logic        tx_pause_req;
   logic        tx_pause_ack;
   cfg_t        cfg_in;
   logic        cfg_valid;
   logic        cfg_ready;
   cfg_t        cfg_out;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  fifo_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   adam_periph_uart_tx_ctrl #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (8),
      .RST_BAUD   (32'd3)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_pause_req    (pause_req),
      .o_pause_ack    (pause_ack),
      .o_tx_pause_req (tx_pause_req),
      .i_tx_pause_ack (tx_pause_ack),
      .i_cfg          (cfg_in),
      .i_cfg_valid    (cfg_valid),
      .o_cfg_ready    (cfg_ready),
      .o_cfg          (cfg_out),
      .i_wr_data      (wr_data),
      .i_wr_valid     (wr_valid),
      .o_wr_ready     (wr_ready),
      .o_tx_data      (tx_data),
      .o_tx_valid     (tx_valid),
      .i_tx_ready     (tx_ready),
      .o_fifo_count   (fifo_count),
      .o_busy         (busy)
   );

   // Behavioural TX partner: takes the head word, sends a frame, raises ready at frame end.
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   int          m_total = 1;
   int          m_bitlen = 1;
   int          m_bit;
   logic [31:0] m_data = '0;
   cfg_t        m_cfg;
   logic        stab_bad = 1'b0;
   logic        tx_line;
   logic [31:0] got_w[$];
   int          got_len[$];

   always @(posedge clk) begin
      if (rst) begin
         m_busy       <= 1'b0;
         tx_ready     <= 1'b0;
         tx_pause_ack <= 1'b0;
         m_cnt        <= 0;
      end else begin
         tx_ready <= 1'b0;
         if (tx_ready && tx_valid) begin
            if (tx_data != m_data) stab_bad <= 1'b1;
            got_w.push_back(tx_data);
            got_len.push_back(m_total);
         end
         if (m_busy) begin
            if (!tx_valid || tx_data != m_data) stab_bad <= 1'b1;
            if (m_cnt == m_total - 1) begin
               m_busy   <= 1'b0;
               tx_ready <= 1'b1;
            end
            m_cnt <= m_cnt + 1;
         end else begin
            tx_pause_ack <= tx_pause_req;
            if (!tx_pause_req && !tx_pause_ack && tx_valid && !tx_ready) begin
               m_busy   <= 1'b1;
               m_cnt    <= 0;
               m_data   <= tx_data;
               m_cfg    <= cfg_out;
               m_bitlen <= int'(cfg_out.baud_rate) + 1;
               m_total  <= (2 + int'(cfg_out.data_length) + int'(cfg_out.parity_control)
                           + int'(cfg_out.stop_bits)) * (int'(cfg_out.baud_rate) + 1);
            end
         end
      end
   end

   assign m_bit = m_busy ? (m_cnt / m_bitlen) : 0;

   always_comb begin
      tx_line = 1'b1;
      if (m_busy) begin
         if (m_bit == 0) begin
            tx_line = 1'b0;
         end else if (m_bit <= int'(m_cfg.data_length)) begin
            tx_line = m_data[m_bit-1];
         end else if (m_cfg.parity_control && m_bit == int'(m_cfg.data_length) + 1) begin
            tx_line = ^(m_data & ((32'h1 << m_cfg.data_length) - 32'h1)) ^ m_cfg.parity_select;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d);
      int t = 0;
      wr_data  = d;
      wr_valid = 1'b1;
      while (!wr_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("push_timeout", 64'(wr_ready), 64'd1);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_hs(input int n);
      int t = 0;
      while (got_w.size() < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) check("hs_timeout", 64'(got_w.size()), 64'(n));
   endtask

   task automatic wait_frame_start();
      int t = 0;
      while (!m_busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("frame_start_timeout", 64'(m_busy), 64'd1);
   endtask

   cfg_t cfg_def;
   cfg_t cfg_a;
   cfg_t cfg_b;
   int   base;
   int   t;
   logic early;

   initial begin
      cfg_def = '{parity_select: 1'b0, parity_control: 1'b0, data_length: 4'd8,
                  stop_bits: 1'b0, baud_rate: 32'd3};
      cfg_a   = '{parity_select: 1'b0, parity_control: 1'b1, data_length: 4'd7,
                  stop_bits: 1'b0, baud_rate: 32'd5};
      cfg_b   = '{parity_select: 1'b1, parity_control: 1'b1, data_length: 4'd8,
                  stop_bits: 1'b1, baud_rate: 32'd3};
      rst       = 1'b1;
      pause_req = 1'b1;
      cfg_in    = cfg_def;
      cfg_valid = 1'b0;
      wr_data   = '0;
      wr_valid  = 1'b0;
      tick(3);
      rst = 1'b0;

      // Reset state
      check("rst_pause_ack", 64'(pause_ack), 64'd1);
      check("rst_tx_pause_req", 64'(tx_pause_req), 64'd1);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      check("rst_fifo_count", 64'(fifo_count), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_cfg_out", 64'(cfg_out), 64'(cfg_def));

      // Two words pushed while paused, then released
      push(32'h55);
      push(32'hA3);
      check("t1_count2", 64'(fifo_count), 64'd2);
      check("t1_head", 64'(tx_data), 64'h55);
      check("t1_busy", 64'(busy), 64'd1);
      pause_req = 1'b0;
      wait_frame_start();
      tick(20);
      check("t1_valid_held", 64'(tx_valid), 64'd1);
      check("t1_data_held", 64'(tx_data), 64'h55);
      wait_hs(1);
      check("t1_count1", 64'(fifo_count), 64'd1);
      check("t1_next_head", 64'(tx_data), 64'hA3);
      wait_hs(2);
      check("t1_count0", 64'(fifo_count), 64'd0);
      check("t1_busy_low", 64'(busy), 64'd0);
      check("t1_word0", 64'(got_w[0]), 64'h55);
      check("t1_word1", 64'(got_w[1]), 64'hA3);
      check("t1_frame_len", 64'(got_len[0]), 64'd40);

      // FIFO fill beyond depth
      base = got_w.size();
      for (int i = 0; i < 8; i++) push(32'hC0DE_0000 + 32'(i * 17));
      check("t2_full_count", 64'(fifo_count), 64'd8);
      check("t2_wr_ready_low", 64'(wr_ready), 64'd0);
      push(32'hC0DE_0088);
      check("t2_ninth_after_pop", 64'(got_w.size()), 64'(base + 1));
      wait_hs(base + 9);
      for (int i = 0; i < 8; i++) check("t2_order", 64'(got_w[base+i]), 64'(32'hC0DE_0000 + 32'(i * 17)));
      check("t2_order_last", 64'(got_w[base+8]), 64'hC0DE_0088);

      // Config change requested mid-frame
      base = got_w.size();
      push(32'h3C);
      push(32'h5A);
      wait_frame_start();
      tick(5);
      cfg_in    = cfg_a;
      cfg_valid = 1'b1;
      tick(1);
      check("t3_tx_pause_req", 64'(tx_pause_req), 64'd1);
      check("t3_no_early_ready", 64'(cfg_ready), 64'd0);
      t = 0;
      while (!cfg_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("t3_ready_seen", 64'(cfg_ready), 64'd1);
      check("t3_frame_done_first", 64'(got_w.size()), 64'(base + 1));
      check("t3_tx_ack_high", 64'(tx_pause_ack), 64'd1);
      tick(1);
      cfg_valid = 1'b0;
      check("t3_cfg_applied", 64'(cfg_out), 64'(cfg_a));
      check("t3_ready_pulse", 64'(cfg_ready), 64'd0);
      wait_hs(base + 2);
      check("t3_word", 64'(got_w[base+1]), 64'h5A);
      check("t3_new_frame_len", 64'(got_len[base+1]), 64'd60);

      // System pause with three words queued
      base = got_w.size();
      push(32'hA1);
      push(32'hB2);
      push(32'hC3);
      wait_frame_start();
      pause_req = 1'b1;
      t = 0;
      while (!pause_ack && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("t4_pause_ack", 64'(pause_ack), 64'd1);
      check("t4_one_sent", 64'(got_w.size()), 64'(base + 1));
      check("t4_count2", 64'(fifo_count), 64'd2);
      tick(100);
      check("t4_still_one", 64'(got_w.size()), 64'(base + 1));
      check("t4_line_idle", 64'(tx_line), 64'd1);
      pause_req = 1'b0;
      tick(2);
      check("t4_ack_released", 64'(pause_ack), 64'd0);
      wait_hs(base + 3);
      check("t4_word_b", 64'(got_w[base+1]), 64'hB2);
      check("t4_word_c", 64'(got_w[base+2]), 64'hC3);

      // Pause and config arriving together in RUN
      tick(3);
      cfg_in    = cfg_b;
      cfg_valid = 1'b1;
      pause_req = 1'b1;
      early     = 1'b0;
      t = 0;
      while (!pause_ack && t < 500) begin
         if (cfg_ready) early = 1'b1;
         @(negedge clk);
         t++;
      end
      check("t5_no_ready_in_drain", 64'(early), 64'd0);
      check("t5_pause_ack", 64'(pause_ack), 64'd1);
      check("t5_ready_in_paused", 64'(cfg_ready), 64'd1);
      tick(1);
      cfg_valid = 1'b0;
      check("t5_cfg_applied", 64'(cfg_out), 64'(cfg_b));
      check("t5_ack_stays", 64'(pause_ack), 64'd1);

      // Reset in the middle of a frame
      pause_req = 1'b0;
      push(32'h01);
      push(32'h02);
      push(32'h03);
      push(32'h04);
      wait_frame_start();
      tick(10);
      rst = 1'b1;
      tick(1);
      check("t6_fifo_count", 64'(fifo_count), 64'd0);
      check("t6_tx_valid", 64'(tx_valid), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_pause_ack", 64'(pause_ack), 64'd1);
      check("t6_tx_pause_req", 64'(tx_pause_req), 64'd1);
      check("t6_cfg_out", 64'(cfg_out), 64'(cfg_def));
      check("t6_wr_ready", 64'(wr_ready), 64'd1);
      check("t6_line", 64'(tx_line), 64'd1);
      rst = 1'b0;
      tick(2);

      check("valid_data_stable", 64'(stab_bad), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
